// File: rtl/cond_pkg.sv
// cond_pkg: shared types and constants for the condition/flag stage.
//   cond_e   : the 4-bit ARM condition field encodings (EQ..AL, plus NV,
//              which this core treats as "always").
//   *_IDX    : bit positions of N, Z, C, V inside a flag vector.
//   flags_t  : the 4-bit flag vector, ordered {N, Z, C, V}.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/cond_check.sv
// cond_check: purely combinational evaluation of an ARM condition field
// against a flag vector.
// Ports:
//   cond    in  4  condition field
//   flags   in  4  flag vector {N, Z, C, V}
//   cond_ex out 1  1 when the condition holds
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  flags_t     flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[N_IDX];
  assign z = flags[Z_IDX];
  assign c = flags[C_IDX];
  assign v = flags[V_IDX];

  always_comb begin
    cond_ex = 1'b1;
    case (cond_e'(cond))
      EQ:      cond_ex = z;
      NE:      cond_ex = ~z;
      CS:      cond_ex = c;
      CC:      cond_ex = ~c;
      MI:      cond_ex = n;
      PL:      cond_ex = ~n;
      VS:      cond_ex = v;
      VC:      cond_ex = ~v;
      HI:      cond_ex = c & ~z;
      LS:      cond_ex = ~c | z;
      GE:      cond_ex = (n == v);
      LT:      cond_ex = (n != v);
      GT:      cond_ex = ~z & (n == v);
      LE:      cond_ex = z | (n != v);
      // AL and the 1111 encoding both execute unconditionally.
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// cond_unit: condition/flag stage after the ALU. Holds the architectural
// flag register, evaluates the instruction condition against it, and gates
// the decoder's PC/register/memory write strobes.
//
// Handshake: valid_i is a qualifier only (no ready/backpressure). When
// valid_i=1 the execute-stage inputs describe a real instruction this cycle;
// when valid_i=0 every other input is ignored (may be X) and no state
// changes apart from CondExR clearing.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   valid_i               instruction present this cycle
//   Cond, ALUFlags        condition field, flags produced by the ALU
//   FlagW                 [1] writes N,Z; [0] writes C,V
//   PCS, RegW, MemW       decoder write requests
//   NoWrite               compare-class op, suppresses RegWrite
//   PCSrc, RegWrite,
//   MemWrite              gated strobes (combinational)
//   CondEx, CondExR       condition result, and its registered copy
//   Flags                 architectural flag register {N,Z,C,V}
//   exec_cnt, skip_cnt    executed / squashed instruction counters
//
// Optional feature macro: COND_PERF_CNT_EN builds the two counters;
// without it exec_cnt/skip_cnt are constant zero.
module cond_unit
  import cond_pkg::*;
#(
  parameter int FLAG_W = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [3:0]        Cond,
  input  logic [FLAG_W-1:0] ALUFlags,
  input  logic [1:0]        FlagW,
  input  logic              PCS,
  input  logic              RegW,
  input  logic              MemW,
  input  logic              NoWrite,
  output logic              PCSrc,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              CondEx,
  output logic              CondExR,
  output logic [FLAG_W-1:0] Flags,
  output logic [CNT_W-1:0]  exec_cnt,
  output logic [CNT_W-1:0]  skip_cnt
);

  flags_t flags_q;
  logic   cond_ex;
  logic   fire;
  logic   wr_nz;
  logic   wr_cv;

  // Condition is judged against the stored flags only, so an instruction
  // never sees the flags it is itself producing.
  cond_check u_check (
    .cond    (Cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  assign fire  = valid_i & cond_ex;
  assign wr_nz = fire & FlagW[1];
  assign wr_cv = fire & FlagW[0];

  assign CondEx   = cond_ex;
  assign PCSrc    = PCS  & fire;
  assign RegWrite = RegW & fire & ~NoWrite;
  assign MemWrite = MemW & fire;
  assign Flags    = flags_q;

  // The two flag halves have independent write enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      if (wr_nz) begin
        flags_q[N_IDX] <= ALUFlags[N_IDX];
        flags_q[Z_IDX] <= ALUFlags[Z_IDX];
      end
      if (wr_cv) begin
        flags_q[C_IDX] <= ALUFlags[C_IDX];
        flags_q[V_IDX] <= ALUFlags[V_IDX];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      CondExR <= 1'b0;
    end else begin
      CondExR <= fire;
    end
  end

`ifdef COND_PERF_CNT_EN
  logic [CNT_W-1:0] exec_q;
  logic [CNT_W-1:0] skip_q;

  // Counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_q <= '0;
      skip_q <= '0;
    end else if (valid_i) begin
      if (cond_ex) begin
        exec_q <= exec_q + 1'b1;
      end else begin
        skip_q <= skip_q + 1'b1;
      end
    end
  end

  assign exec_cnt = exec_q;
  assign skip_cnt = skip_q;
`else
  assign exec_cnt = '0;
  assign skip_cnt = '0;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed bench for cond_unit. Each driven cycle pushes its
// hand-computed expected outputs into exp_q; a monitor on the falling edge
// pops and compares. Counter and async-reset checks are done inline.
module tb_cond_unit;

  localparam int CNT_W = 4;
  localparam int EW    = 9; // {condex, pcsrc, regwrite, memwrite, flags[3:0], condexr}

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic             valid_i = 1'b0;
  logic [3:0]       Cond     = 4'h0;
  logic [3:0]       ALUFlags = 4'h0;
  logic [1:0]       FlagW    = 2'b00;
  logic             PCS = 1'b0, RegW = 1'b0, MemW = 1'b0, NoWrite = 1'b0;
  logic             PCSrc, RegWrite, MemWrite, CondEx, CondExR;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] exec_cnt, skip_cnt;

  cond_unit #(.FLAG_W(4), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (valid_i),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .NoWrite  (NoWrite),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .CondEx   (CondEx),
    .CondExR  (CondExR),
    .Flags    (Flags),
    .exec_cnt (exec_cnt),
    .skip_cnt (skip_cnt)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int vec_id = 0;
  logic [EW-1:0] exp_q[$];
  int            id_q[$];

  // ---------------- driver tasks ----------------
  // Apply one cycle of inputs just after the rising edge and queue what the
  // outputs must look like during that cycle.
  task automatic drive(input logic v, input logic [3:0] c, input logic [3:0] alu,
                       input logic [1:0] fw, input logic pcs, input logic regw,
                       input logic memw, input logic nw,
                       input logic e_ce, input logic e_pc, input logic e_rw,
                       input logic e_mw, input logic [3:0] e_fl, input logic e_cr);
    @(posedge clk);
    #1;
    valid_i  = v;
    Cond     = c;
    ALUFlags = alu;
    FlagW    = fw;
    PCS      = pcs;
    RegW     = regw;
    MemW     = memw;
    NoWrite  = nw;
    exp_q.push_back({e_ce, e_pc, e_rw, e_mw, e_fl, e_cr});
    id_q.push_back(vec_id);
    vec_id++;
  endtask

  // Let the last driven cycle reach its edge, then go idle.
  task automatic settle();
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    FlagW   = 2'b00;
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      logic [EW-1:0] a;
      int            id;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      a  = {CondEx, PCSrc, RegWrite, MemWrite, Flags, CondExR};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL vec%0d {condex,pcsrc,regwrite,memwrite,flags,condexr}: got %b expected %b",
                 id, a, e);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [CNT_W-1:0] exp_exec;
    logic [CNT_W-1:0] exp_skip;

    // Reset held across the first edge.
    #8;
    check_val("reset_flags",   32'(Flags),   32'h0);
    check_val("reset_condexr", 32'(CondExR), 32'h0);
    check_val("reset_exec",    32'(exec_cnt), 32'h0);
    check_val("reset_skip",    32'(skip_cnt), 32'h0);
    #4 rst_n = 1'b1;

    //     v  cond   alu    fw    pcs rw mw nw   ce pc rw mw flags  cr
    drive(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0,   0, 0, 0, 0, 4'h0, 0); // idle, EQ with Z=0
    drive(1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0,   1, 0, 1, 0, 4'h0, 0); // AL register write
    drive(1, 4'hE, 4'h6, 2'b11, 0, 1, 0, 1,   1, 0, 0, 0, 4'h0, 1); // CMP sets Z,C
    drive(1, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0,   1, 1, 0, 0, 4'h6, 1); // EQ branch taken
    drive(1, 4'h1, 4'h0, 2'b00, 1, 0, 0, 0,   0, 0, 0, 0, 4'h6, 1); // NE branch squashed
    drive(0, 4'hE, 4'hF, 2'b11, 1, 1, 1, 0,   1, 0, 0, 0, 4'h6, 0); // invalid: no strobes, no write
    drive(1, 4'hE, 4'h0, 2'b11, 0, 0, 1, 0,   1, 0, 0, 1, 4'h6, 0); // store, clear flags
    drive(1, 4'hE, 4'hB, 2'b10, 0, 0, 0, 0,   1, 0, 0, 0, 4'h0, 1); // write N,Z only
    drive(1, 4'hA, 4'h0, 2'b11, 0, 1, 0, 0,   0, 0, 0, 0, 4'h8, 1); // GE fails, flag write dropped
    drive(1, 4'hB, 4'h0, 2'b00, 0, 1, 0, 0,   1, 0, 1, 0, 4'h8, 0); // LT passes
    drive(1, 4'hE, 4'h1, 2'b01, 0, 0, 0, 0,   1, 0, 0, 0, 4'h8, 1); // write C,V only
    drive(1, 4'hA, 4'h0, 2'b00, 0, 0, 0, 0,   1, 0, 0, 0, 4'h9, 1); // GE passes
    drive(1, 4'hC, 4'h0, 2'b00, 0, 0, 0, 0,   1, 0, 0, 0, 4'h9, 1); // GT passes
    drive(1, 4'hD, 4'h4, 2'b11, 0, 0, 0, 0,   0, 0, 0, 0, 4'h9, 1); // LE fails, no write
    drive(1, 4'h8, 4'h0, 2'b00, 0, 0, 0, 0,   0, 0, 0, 0, 4'h9, 0); // HI fails (C=0)
    drive(1, 4'h9, 4'h0, 2'b00, 0, 0, 0, 0,   1, 0, 0, 0, 4'h9, 0); // LS passes
    drive(1, 4'hF, 4'h0, 2'b00, 1, 0, 1, 0,   1, 1, 0, 1, 4'h9, 1); // 1111 executes
    drive(1, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0,   1, 0, 0, 0, 4'h9, 1); // set all flags
    drive(1, 4'h6, 4'h0, 2'b00, 0, 1, 0, 0,   1, 0, 1, 0, 4'hF, 1); // VS passes

    // Async reset between edges, with a flag write pending.
    ALUFlags = 4'h0;
    FlagW    = 2'b11;
    Cond     = 4'hE;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_flags",   32'(Flags),   32'h0);
    check_val("async_rst_condexr", 32'(CondExR), 32'h0);
    valid_i = 1'b0;
    FlagW   = 2'b00;
    #1 rst_n = 1'b1;

    // Counters: 5 executed, 3 squashed (Z=0 so EQ fails).
    for (int i = 0; i < 5; i++)
      drive(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0,   1, 0, 0, 0, 4'h0, (i == 0) ? 1'b0 : 1'b1);
    for (int i = 0; i < 3; i++)
      drive(1, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0,   0, 0, 0, 0, 4'h0, (i == 0) ? 1'b1 : 1'b0);
    settle();
`ifdef COND_PERF_CNT_EN
    exp_exec = CNT_W'(5);
    exp_skip = CNT_W'(3);
`else
    exp_exec = '0;
    exp_skip = '0;
`endif
    check_val("exec_cnt_5", 32'(exec_cnt), 32'(exp_exec));
    check_val("skip_cnt_3", 32'(skip_cnt), 32'(exp_skip));

    // Bring exec_cnt to all-ones, then one more pass wraps it to zero.
    for (int i = 0; i < 10; i++)
      drive(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0,   1, 0, 0, 0, 4'h0, (i == 0) ? 1'b0 : 1'b1);
    settle();
`ifdef COND_PERF_CNT_EN
    exp_exec = '1;
`else
    exp_exec = '0;
`endif
    check_val("exec_cnt_max", 32'(exec_cnt), 32'(exp_exec));
    drive(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0,   1, 0, 0, 0, 4'h0, 0);
    settle();
    check_val("exec_cnt_wrap", 32'(exec_cnt), 32'h0);
    check_val("skip_cnt_hold", 32'(skip_cnt), 32'(exp_skip));

    // Drain and report.
    repeat (3) @(posedge clk);
    check_val("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
